// File: rtl/ll_multi_queue_ctrl.sv
// Multi-queue linked-list engine: NUM_QUEUES FIFOs share one LL_DEPTH-entry pool.
// The free list is built by an init walk after reset. Dequeue data is returned READ_DELAY cycles after the request.
module ll_multi_queue_ctrl #(
  parameter int NUM_QUEUES = 4,
  parameter int LL_DEPTH   = 64,
  parameter int DATA_WIDTH = 6,
  parameter int READ_DELAY = 3,
  parameter int AFULL_THR  = 8,
  localparam int ID_W  = $clog2(NUM_QUEUES),
  localparam int CNT_W = $clog2(LL_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        init_done,
  input  logic                        enq_vld_in,
  input  logic [ID_W-1:0]             enq_id_in,
  input  logic [DATA_WIDTH-1:0]       enq_data_in,
  input  logic                        deq_vld_in,
  input  logic [ID_W-1:0]             deq_id_in,
  output logic                        deq_vld_out,
  output logic [ID_W-1:0]             deq_id_out,
  output logic [DATA_WIDTH-1:0]       deq_data_out,
  output logic [NUM_QUEUES*CNT_W-1:0] q_cnt_out,
  output logic [CNT_W-1:0]            free_cnt_out,
  output logic [NUM_QUEUES-1:0]       q_empty_out,
  output logic [NUM_QUEUES-1:0]       q_afull_out,
  output logic                        full_out,
  output logic                        enq_err_out,
  output logic                        deq_err_out
);
  localparam int AW = $clog2(LL_DEPTH);
  typedef logic [AW-1:0]    addr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  addr_t                 init_ptr;
  logic                  init_last, run;
  addr_t                 next_mem [LL_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [LL_DEPTH];
  addr_t                 q_head [NUM_QUEUES];
  addr_t                 q_tail [NUM_QUEUES];
  cnt_t                  q_cnt  [NUM_QUEUES];
  addr_t                 free_head, free_tail;
  cnt_t                  free_cnt;
  logic                  enq_ok, deq_ok, same_q, enq_reuse_head;
  addr_t                 enq_addr, deq_addr;
  logic [NUM_QUEUES-1:0] enq_hit, deq_hit;

  logic                  pipe_vld  [READ_DELAY];
  logic [ID_W-1:0]       pipe_id   [READ_DELAY];
  logic [DATA_WIDTH-1:0] pipe_data [READ_DELAY];

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_last) state_d = S_RUN;
  end

  assign init_last = (init_ptr == addr_t'(LL_DEPTH - 1));
  assign run       = (state_q == S_RUN);
  assign init_done = run;
  assign enq_ok    = run && enq_vld_in && (free_cnt != '0);
  assign deq_ok    = run && deq_vld_in && (q_cnt[deq_id_in] != '0);
  assign same_q    = (enq_id_in == deq_id_in);
  assign enq_addr  = free_head;
  assign deq_addr  = q_head[deq_id_in];
  // New entry becomes head when its queue is empty, or is emptied by the same-cycle dequeue.
  assign enq_reuse_head = (q_cnt[enq_id_in] == '0) ||
                          (deq_ok && same_q && q_cnt[enq_id_in] == cnt_t'(1));

  always_comb begin
    enq_hit = '0;
    deq_hit = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      enq_hit[i] = enq_ok && (enq_id_in == ID_W'(i));
      deq_hit[i] = deq_ok && (deq_id_in == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      init_ptr    <= '0;
      free_head   <= '0;
      free_tail   <= addr_t'(LL_DEPTH - 1);
      free_cnt    <= '0;
      enq_err_out <= 1'b0;
      deq_err_out <= 1'b0;
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        q_head[i] <= '0;
        q_tail[i] <= '0;
        q_cnt[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      enq_err_out <= run && enq_vld_in && (free_cnt == '0);
      deq_err_out <= run && deq_vld_in && (q_cnt[deq_id_in] == '0);
      if (state_q == S_INIT) begin
        init_ptr <= init_ptr + addr_t'(1);
        if (init_last) free_cnt <= cnt_t'(LL_DEPTH);
      end
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        if (enq_hit[i] && !deq_hit[i]) q_cnt[i] <= q_cnt[i] + cnt_t'(1);
        if (deq_hit[i] && !enq_hit[i]) q_cnt[i] <= q_cnt[i] - cnt_t'(1);
        if (enq_hit[i] && enq_reuse_head) q_head[i] <= enq_addr;
        else if (deq_hit[i])              q_head[i] <= next_mem[q_head[i]];
        if (enq_hit[i]) q_tail[i] <= enq_addr;
      end
      // Free list: pop at head for enqueue, push at tail for dequeue.
      if (enq_ok && deq_ok) begin
        free_head <= (free_cnt == cnt_t'(1)) ? deq_addr : next_mem[free_head];
        free_tail <= deq_addr;
      end else if (enq_ok) begin
        free_head <= next_mem[free_head];
        free_cnt  <= free_cnt - cnt_t'(1);
      end else if (deq_ok) begin
        if (free_cnt == '0) free_head <= deq_addr;
        free_tail <= deq_addr;
        free_cnt  <= free_cnt + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) next_mem[init_ptr] <= init_ptr + addr_t'(1);
    if (enq_ok) begin
      data_mem[enq_addr] <= enq_data_in;
      if (!enq_reuse_head) next_mem[q_tail[enq_id_in]] <= enq_addr;
    end
    if (deq_ok && free_cnt != '0 && !(enq_ok && free_cnt == cnt_t'(1)))
      next_mem[free_tail] <= deq_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_DELAY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_id[i]   <= '0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= deq_ok;
      if (deq_ok) begin
        pipe_id[0]   <= deq_id_in;
        pipe_data[0] <= data_mem[deq_addr];
      end
      for (int unsigned i = 1; i < READ_DELAY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_id[i]   <= pipe_id[i-1];
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign deq_vld_out  = pipe_vld[READ_DELAY-1];
  assign deq_id_out   = pipe_id[READ_DELAY-1];
  assign deq_data_out = pipe_data[READ_DELAY-1];
  assign free_cnt_out = free_cnt;
  assign full_out     = (free_cnt == '0);

  always_comb begin
    q_cnt_out   = '0;
    q_empty_out = '0;
    q_afull_out = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      q_cnt_out[i*CNT_W +: CNT_W] = q_cnt[i];
      q_empty_out[i]              = (q_cnt[i] == '0);
      q_afull_out[i]              = (q_cnt[i] >= cnt_t'(AFULL_THR));
    end
  end
endmodule

// File: tb/tb_ll_multi_queue_ctrl.sv
// Bench for ll_multi_queue_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_ll_multi_queue_ctrl;
  localparam int NQ = 4, DEPTH = 64, DW = 6, RD = 3, THR = 8;
  localparam int IDW = $clog2(NQ), CW = $clog2(DEPTH + 1);

  logic clk = 1'b0, reset = 1'b1;
  logic init_done;
  logic enq_vld_in = 1'b0, deq_vld_in = 1'b0;
  logic [IDW-1:0] enq_id_in = '0, deq_id_in = '0;
  logic [DW-1:0] enq_data_in = '0;
  logic deq_vld_out, full_out, enq_err_out, deq_err_out;
  logic [IDW-1:0] deq_id_out;
  logic [DW-1:0] deq_data_out;
  logic [NQ*CW-1:0] q_cnt_out;
  logic [CW-1:0] free_cnt_out;
  logic [NQ-1:0] q_empty_out, q_afull_out;

  ll_multi_queue_ctrl #(.NUM_QUEUES(NQ), .LL_DEPTH(DEPTH), .DATA_WIDTH(DW),
                        .READ_DELAY(RD), .AFULL_THR(THR)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .enq_vld_in(enq_vld_in), .enq_id_in(enq_id_in), .enq_data_in(enq_data_in),
    .deq_vld_in(deq_vld_in), .deq_id_in(deq_id_in),
    .deq_vld_out(deq_vld_out), .deq_id_out(deq_id_out), .deq_data_out(deq_data_out),
    .q_cnt_out(q_cnt_out), .free_cnt_out(free_cnt_out), .q_empty_out(q_empty_out),
    .q_afull_out(q_afull_out), .full_out(full_out),
    .enq_err_out(enq_err_out), .deq_err_out(deq_err_out));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct { int due; logic [IDW-1:0] id; logic [DW-1:0] data; } pend_t;
  logic [DW-1:0] mq [NQ][$];
  pend_t pend [$];
  int cyc = 0, m_init = 0;
  bit m_run = 0;
  logic exp_vld = 0, exp_enq_err = 0, exp_deq_err = 0;
  logic [IDW-1:0] exp_id = '0;
  logic [DW-1:0] exp_data = '0;

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < NQ; i++) t += mq[i].size();
    return t;
  endfunction

  // Advance one clock edge and update the reference model from the inputs sampled at that edge.
  task automatic cycle();
    int total;
    pend_t p;
    @(posedge clk);
    cyc++;
    exp_enq_err = 0;
    exp_deq_err = 0;
    if (reset) begin
      for (int i = 0; i < NQ; i++) mq[i].delete();
      pend.delete();
      m_run = 0; m_init = 0; exp_id = '0; exp_data = '0;
    end else if (!m_run) begin
      m_init++;
      if (m_init == DEPTH) m_run = 1;
    end else begin
      total = model_total();
      exp_enq_err = enq_vld_in && (total == DEPTH);
      exp_deq_err = deq_vld_in && (mq[deq_id_in].size() == 0);
      if (deq_vld_in && mq[deq_id_in].size() != 0) begin
        p.due = cyc + RD - 1; p.id = deq_id_in; p.data = mq[deq_id_in].pop_front();
        pend.push_back(p);
      end
      if (enq_vld_in && total < DEPTH) mq[enq_id_in].push_back(enq_data_in);
    end
    exp_vld = 0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      exp_vld = 1; exp_id = p.id; exp_data = p.data;
    end
    #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    cycle(); cycle();
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
    checks++; if (free_cnt_out !== '0) begin errors++; $display("FAIL reset_free_cnt got %0d exp 0", free_cnt_out); end
    checks++; if (full_out !== 1'b1) begin errors++; $display("FAIL reset_full got %b exp 1", full_out); end
    checks++; if (q_empty_out !== '1) begin errors++; $display("FAIL reset_empty got %b exp 1111", q_empty_out); end
    checks++; if (q_cnt_out !== '0 || q_afull_out !== '0) begin errors++; $display("FAIL reset_counts got %h/%b exp 0/0", q_cnt_out, q_afull_out); end
    checks++; if (deq_vld_out !== 1'b0 || deq_data_out !== '0 || deq_id_out !== '0) begin
      errors++; $display("FAIL reset_deq_out got %b/%0d/%0d exp 0/0/0", deq_vld_out, deq_id_out, deq_data_out); end
    reset = 1'b0;
    enq_vld_in = 1'b1; enq_id_in = 2'd1; deq_vld_in = 1'b1; deq_id_in = 2'd1;
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      cycle();
      checks++; if (enq_err_out !== 1'b0 || deq_err_out !== 1'b0) begin
        errors++; $display("FAIL init_err cycle %0d got %b%b exp 00", k, enq_err_out, deq_err_out); end
      if (init_done === 1'b1) begin n = k; break; end
    end
    enq_vld_in = 1'b0; deq_vld_in = 1'b0;
    checks++; if (n != DEPTH) begin errors++; $display("FAIL init_cycles got %0d exp %0d", n, DEPTH); end
    checks++; if (free_cnt_out !== CW'(DEPTH)) begin errors++; $display("FAIL init_free_cnt got %0d exp %0d", free_cnt_out, DEPTH); end
    checks++; if (q_empty_out !== '1 || q_cnt_out !== '0) begin errors++; $display("FAIL init_queues got %b/%h exp 1111/0", q_empty_out, q_cnt_out); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [3];
    logic [DW-1:0] got [$];
    int first, last;
    vals[0] = 6'd5; vals[1] = 6'd9; vals[2] = 6'd17;
    for (int k = 0; k < 3; k++) begin
      enq_vld_in = 1'b1; enq_id_in = 2'd2; enq_data_in = vals[k];
      cycle();
    end
    enq_vld_in = 1'b0;
    checks++; if (q_cnt_out[2*CW +: CW] !== CW'(3)) begin errors++; $display("FAIL basic_cnt got %0d exp 3", q_cnt_out[2*CW +: CW]); end
    checks++; if (free_cnt_out !== CW'(DEPTH - 3)) begin errors++; $display("FAIL basic_free got %0d exp %0d", free_cnt_out, DEPTH - 3); end
    deq_vld_in = 1'b1; deq_id_in = 2'd2;
    first = -1; last = -1;
    for (int n = 1; n <= 10; n++) begin
      cycle();
      if (n == 3) deq_vld_in = 1'b0;
      if (deq_vld_out === 1'b1) begin
        got.push_back(deq_data_out);
        if (first < 0) first = n;
        last = n;
        checks++; if (deq_id_out !== 2'd2) begin errors++; $display("FAIL basic_id got %0d exp 2", deq_id_out); end
      end
    end
    checks++; if (first != RD || last != RD + 2) begin errors++; $display("FAIL basic_latency got %0d..%0d exp %0d..%0d", first, last, RD, RD + 2); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++; if (got[k] !== vals[k]) begin errors++; $display("FAIL basic_data[%0d] got %0d exp %0d", k, got[k], vals[k]); end
    end
    checks++; if (q_empty_out !== '1) begin errors++; $display("FAIL basic_empty got %b exp 1111", q_empty_out); end
  endtask

  task automatic test_full();
    logic [NQ*CW-1:0] saved;
    int rr;
    for (int k = 0; k < DEPTH; k++) begin
      enq_vld_in = 1'b1; enq_id_in = IDW'(k % NQ); enq_data_in = DW'($urandom);
      cycle();
    end
    checks++; if (full_out !== 1'b1 || free_cnt_out !== '0) begin errors++; $display("FAIL full_flag got %b/%0d exp 1/0", full_out, free_cnt_out); end
    checks++; if (q_afull_out !== '1) begin errors++; $display("FAIL full_afull got %b exp 1111", q_afull_out); end
    saved = q_cnt_out;
    enq_id_in = 2'd1; cycle();
    checks++; if (enq_err_out !== 1'b1) begin errors++; $display("FAIL full_enq_err got %b exp 1", enq_err_out); end
    checks++; if (q_cnt_out !== saved || free_cnt_out !== '0) begin errors++; $display("FAIL full_counts got %h exp %h", q_cnt_out, saved); end
    enq_vld_in = 1'b0; cycle();
    checks++; if (enq_err_out !== 1'b0) begin errors++; $display("FAIL full_err_pulse got %b exp 0", enq_err_out); end
    enq_vld_in = 1'b1; enq_id_in = 2'd0; deq_vld_in = 1'b1; deq_id_in = 2'd1;
    cycle();
    enq_vld_in = 1'b0; deq_vld_in = 1'b0;
    checks++; if (enq_err_out !== 1'b1 || deq_err_out !== 1'b0) begin errors++; $display("FAIL full_simul_err got %b%b exp 10", enq_err_out, deq_err_out); end
    checks++; if (free_cnt_out !== CW'(1) || q_cnt_out[1*CW +: CW] !== CW'(15) || q_cnt_out[0 +: CW] !== CW'(16)) begin
      errors++; $display("FAIL full_simul_cnt got free %0d q0 %0d q1 %0d exp 1 16 15", free_cnt_out, q_cnt_out[0 +: CW], q_cnt_out[CW +: CW]); end
    rr = 0;
    for (int n = 0; n < 80; n++) begin
      deq_vld_in = 1'b0;
      for (int j = 0; j < NQ; j++)
        if (!deq_vld_in && mq[(rr + j) % NQ].size() != 0) begin
          deq_vld_in = 1'b1; deq_id_in = IDW'((rr + j) % NQ); rr = (rr + j + 1) % NQ;
        end
      cycle();
      checks++; if (deq_vld_out !== exp_vld || (exp_vld && deq_data_out !== exp_data)) begin
        errors++; $display("FAIL drain_out got %b/%0d exp %b/%0d", deq_vld_out, deq_data_out, exp_vld, exp_data); end
    end
    deq_vld_in = 1'b0;
    checks++; if (free_cnt_out !== CW'(DEPTH) || q_empty_out !== '1) begin errors++; $display("FAIL drain_final got %0d/%b exp %0d/1111", free_cnt_out, q_empty_out, DEPTH); end
  endtask

  task automatic test_errors();
    logic [DW-1:0] got [$];
    deq_vld_in = 1'b1; deq_id_in = 2'd1; cycle();
    deq_vld_in = 1'b0;
    checks++; if (deq_err_out !== 1'b1) begin errors++; $display("FAIL empty_deq_err got %b exp 1", deq_err_out); end
    for (int n = 0; n <= RD; n++) begin
      cycle();
      checks++; if (deq_vld_out !== 1'b0 || deq_err_out !== 1'b0) begin errors++; $display("FAIL empty_deq_out got %b%b exp 00", deq_vld_out, deq_err_out); end
    end
    enq_vld_in = 1'b1; enq_id_in = 2'd0; enq_data_in = 6'd21; cycle();
    enq_data_in = 6'd42; deq_vld_in = 1'b1; deq_id_in = 2'd0; cycle();
    enq_vld_in = 1'b0; deq_vld_in = 1'b0;
    if (deq_vld_out === 1'b1) got.push_back(deq_data_out);
    checks++; if (q_cnt_out[0 +: CW] !== CW'(1) || enq_err_out !== 1'b0 || deq_err_out !== 1'b0) begin
      errors++; $display("FAIL simul_q0 got cnt %0d err %b%b exp 1 00", q_cnt_out[0 +: CW], enq_err_out, deq_err_out); end
    deq_vld_in = 1'b1; cycle();
    deq_vld_in = 1'b0;
    if (deq_vld_out === 1'b1) got.push_back(deq_data_out);
    for (int n = 0; n < RD + 2; n++) begin
      cycle();
      if (deq_vld_out === 1'b1) got.push_back(deq_data_out);
    end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL simul_outputs got %0d exp 2", got.size()); end
    else begin
      checks++; if (got[0] !== 6'd21 || got[1] !== 6'd42) begin errors++; $display("FAIL simul_order got %0d,%0d exp 21,42", got[0], got[1]); end
    end
    checks++; if (q_empty_out[0] !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", q_empty_out[0]); end
  endtask

  task automatic test_afull();
    for (int k = 0; k < THR; k++) begin
      enq_vld_in = 1'b1; enq_id_in = 2'd3; enq_data_in = DW'(k + 30);
      cycle();
      checks++; if (q_afull_out[3] !== (k + 1 >= THR)) begin errors++; $display("FAIL afull_rise n=%0d got %b exp %b", k + 1, q_afull_out[3], k + 1 >= THR); end
    end
    enq_vld_in = 1'b0;
    deq_vld_in = 1'b1; deq_id_in = 2'd3; cycle();
    deq_vld_in = 1'b0;
    checks++; if (q_afull_out[3] !== 1'b0 || q_cnt_out[3*CW +: CW] !== CW'(THR - 1)) begin
      errors++; $display("FAIL afull_fall got %b/%0d exp 0/%0d", q_afull_out[3], q_cnt_out[3*CW +: CW], THR - 1); end
    for (int n = 0; n < THR + RD + 2; n++) begin
      deq_vld_in = (mq[3].size() != 0);
      cycle();
      checks++; if (deq_vld_out !== exp_vld || (exp_vld && deq_data_out !== exp_data)) begin
        errors++; $display("FAIL afull_drain got %b/%0d exp %b/%0d", deq_vld_out, deq_data_out, exp_vld, exp_data); end
    end
    deq_vld_in = 1'b0;
  endtask

  task automatic test_random();
    int sum, enq_pct, deq_pct;
    for (int n = 0; n < 2000; n++) begin
      reset = (n >= 1000 && n < 1003);
      enq_pct = ((n % 400) < 200) ? 70 : 30;
      deq_pct = ((n % 400) < 200) ? 40 : 70;
      enq_vld_in = ($urandom_range(0, 99) < enq_pct);
      enq_id_in = IDW'($urandom_range(0, NQ - 1));
      enq_data_in = DW'($urandom);
      deq_vld_in = ($urandom_range(0, 99) < deq_pct);
      deq_id_in = IDW'($urandom_range(0, NQ - 1));
      cycle();
      if (n == 1002) begin
        checks++; if (init_done !== 1'b0 || free_cnt_out !== '0 || deq_vld_out !== 1'b0 || deq_data_out !== '0 || q_empty_out !== '1) begin
          errors++; $display("FAIL midreset got done %b free %0d vld %b data %0d empty %b", init_done, free_cnt_out, deq_vld_out, deq_data_out, q_empty_out); end
      end
      checks++; if (init_done !== m_run) begin errors++; $display("FAIL rnd_init_done cyc %0d got %b exp %b", n, init_done, m_run); end
      checks++; if (free_cnt_out !== CW'(m_run ? DEPTH - model_total() : 0)) begin
        errors++; $display("FAIL rnd_free cyc %0d got %0d exp %0d", n, free_cnt_out, m_run ? DEPTH - model_total() : 0); end
      checks++; if (full_out !== (!m_run || model_total() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc %0d got %b", n, full_out); end
      for (int i = 0; i < NQ; i++) begin
        checks++; if (q_cnt_out[i*CW +: CW] !== CW'(mq[i].size()) || q_empty_out[i] !== (mq[i].size() == 0) || q_afull_out[i] !== (mq[i].size() >= THR)) begin
          errors++; $display("FAIL rnd_q%0d cyc %0d got %0d/%b/%b exp %0d", i, n, q_cnt_out[i*CW +: CW], q_empty_out[i], q_afull_out[i], mq[i].size()); end
      end
      checks++; if (enq_err_out !== exp_enq_err || deq_err_out !== exp_deq_err) begin
        errors++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", n, enq_err_out, deq_err_out, exp_enq_err, exp_deq_err); end
      checks++; if (deq_vld_out !== exp_vld || deq_data_out !== exp_data || (exp_vld && deq_id_out !== exp_id)) begin
        errors++; $display("FAIL rnd_deq cyc %0d got %b/%0d/%0d exp %b/%0d/%0d", n, deq_vld_out, deq_id_out, deq_data_out, exp_vld, exp_id, exp_data); end
      if (init_done === 1'b1) begin
        sum = free_cnt_out;
        for (int i = 0; i < NQ; i++) sum += q_cnt_out[i*CW +: CW];
        checks++; if (sum != DEPTH) begin errors++; $display("FAIL rnd_invariant cyc %0d got %0d exp %0d", n, sum, DEPTH); end
      end
    end
    reset = 1'b0; enq_vld_in = 1'b0; deq_vld_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_errors();
    test_afull();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
